// File: rtl/trg_link_pkg.sv
// Shared constants and types for the trigger-link frame transmitter.
package trg_link_pkg;

    localparam logic [7:0]  K_BC      = 8'hBC;
    localparam logic [7:0]  K_F7      = 8'hF7;
    localparam logic [7:0]  K_FB      = 8'hFB;
    localparam logic [7:0]  K_FD      = 8'hFD;
    localparam logic [7:0]  K_FC      = 8'hFC;

    localparam logic [31:0] SYNC_WORD = 32'h50BC50BC;
    localparam logic [3:0]  SYNC_ISK  = 4'b0101;
    localparam logic [3:0]  LAST_ISK  = 4'b0001;

    typedef enum logic [1:0] {
        MODE_DATA = 2'd0,
        MODE_PRBS = 2'd1,
        MODE_CNT  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_e;

    // Frame separator K-code for a 2-bit selector
    function automatic logic [7:0] ksep_sel(input logic [1:0] sel);
        case (sel)
            2'd0:    return K_BC;
            2'd1:    return K_F7;
            2'd2:    return K_FB;
            default: return K_FD;
        endcase
    endfunction

endpackage

// File: rtl/trg_frame_tx_prbs31_par.sv
// PRBS-31 (x^31 + x^28 + 1) generator producing NBITS serial steps per advance.
module prbs31_par #(
    parameter int unsigned NBITS = 56,
    parameter logic [30:0] SEED  = 31'h7FFFFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_load,
    input  logic             advance,
    output logic [30:0]      lfsr_nxt,
    output logic [NBITS-1:0] bits
);

    logic [30:0] lfsr_q;

    // Serial LFSR unrolled NBITS times; first generated bit lands in the MSB
    always_comb begin
        logic [30:0] s;
        logic        fb;
        s    = lfsr_q;
        fb   = 1'b0;
        bits = '0;
        for (int unsigned i = 0; i < NBITS; i++) begin
            fb                = s[30] ^ s[27];
            bits[NBITS-1-i]   = fb;
            s                 = {s[29:0], fb};
        end
        lfsr_nxt = s;
    end

    // LFSR state: seed has priority over advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else if (seed_load) begin
            lfsr_q <= SEED;
        end else if (advance) begin
            lfsr_q <= lfsr_nxt;
        end
    end

endmodule

// File: rtl/trg_frame_tx.sv
// Trigger-link frame builder: WORDS x 32-bit GTX words per frame, payload + K separator.
module trg_frame_tx
    import trg_link_pkg::*;
#(
    parameter int unsigned  WORDS       = 2,
    parameter int unsigned  SYNC_FRAMES = 16,
    parameter bit           KSEL_TTC    = 1'b1,
    parameter logic [30:0]  PRBS_SEED   = 31'h7FFFFFFF,
    localparam int unsigned DATA_WIDTH  = 32*WORDS-8
) (
    input  logic                  TRG_CLK80,
    input  logic                  TRG_RST_N,
    input  logic                  TX_SYNC_DONE,
    input  logic                  SYNC_REQ,
    input  logic [1:0]            MODE,
    input  logic                  INJ_ERR,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  OVERFLOW,
    input  logic [11:0]           BXN_COUNTER,
    output logic [31:0]           TRG_TX_DATA,
    output logic [3:0]            TRG_TX_ISK,
    output logic                  FRAME_START,
    output logic                  LTNCY_TRIG,
    output logic                  LINK_READY
);

    localparam logic [1:0] LAST_WORD = 2'(WORDS-1);

    state_e                  state, state_nxt;
    logic [1:0]              word_cnt, wc_nxt;
    logic [7:0]              sync_cnt;
    logic [7:0]              frame_cnt, frame_cnt_nxt;
    logic                    sync_req_r;
    logic                    inj_d, inj_flag, inj_pend;
    logic                    boundary, load, sync_entry;
    mode_e                   mode_eff;
    logic [DATA_WIDTH-1:0]   payload_r, payload_nxt, payload_cur;
    logic [7:0]              ksep_r, ksep_nxt, ksep_cur;
    logic [32*WORDS-1:0]     frame_vec;
    logic [31:0]             tx_word;
    logic [3:0]              tx_isk;
    logic [DATA_WIDTH-1:0]   prbs_bits;
    logic [30:0]             lfsr_nxt_unused;
    logic                    bxn_unused;

    // Only the two low bunch-counter bits select the separator
    assign bxn_unused = ^BXN_COUNTER[11:2];
    assign LINK_READY = (state == RUN);

    prbs31_par #(
        .NBITS (DATA_WIDTH),
        .SEED  (PRBS_SEED)
    ) u_prbs (
        .clk       (TRG_CLK80),
        .rst_n     (TRG_RST_N),
        .seed_load (state_nxt != RUN),
        .advance   (load),
        .lfsr_nxt  (lfsr_nxt_unused),
        .bits      (prbs_bits)
    );

    // Next-state, word counter and frame counter decode
    always_comb begin
        state_nxt     = state;
        boundary      = (word_cnt == LAST_WORD);
        if (!TX_SYNC_DONE) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (word_cnt == '0) state_nxt = SYNC;
                SYNC:    if (boundary && sync_cnt == 8'(SYNC_FRAMES-1)) state_nxt = RUN;
                RUN:     if (boundary && (sync_req_r || SYNC_REQ)) state_nxt = SYNC;
                default: state_nxt = IDLE;
            endcase
        end
        wc_nxt        = (!TX_SYNC_DONE || boundary) ? 2'd0 : word_cnt + 2'd1;
        load          = boundary && (state_nxt == RUN);
        sync_entry    = (state_nxt == SYNC) && (state != SYNC);
        frame_cnt_nxt = frame_cnt;
        if (state_nxt != RUN) begin
            frame_cnt_nxt = '0;
        end else if (state == RUN && boundary) begin
            frame_cnt_nxt = frame_cnt + 8'd1;
        end
    end

    // Payload/separator selection and outgoing word mux
    always_comb begin
        mode_eff = (MODE == MODE_RSVD) ? MODE_DATA : mode_e'(MODE);
        inj_pend = inj_flag | (INJ_ERR & ~inj_d);
        case (mode_eff)
            MODE_PRBS: payload_nxt = prbs_bits;
            // Counter payload carries the count of the frame it travels in
            MODE_CNT:  payload_nxt = {(DATA_WIDTH/8){frame_cnt_nxt}};
            default:   payload_nxt = DATA_IN;
        endcase
        payload_nxt[0] = payload_nxt[0] ^ inj_pend;
        // Local separator counter equals the low bits of the RUN frame count
        if (OVERFLOW && mode_eff == MODE_DATA) begin
            ksep_nxt = K_FC;
        end else begin
            ksep_nxt = ksep_sel(KSEL_TTC ? BXN_COUNTER[1:0] : frame_cnt_nxt[1:0]);
        end
        // Word 0 leaves on the load edge itself, so bypass the frame registers then
        payload_cur = load ? payload_nxt : payload_r;
        ksep_cur    = load ? ksep_nxt : ksep_r;
        frame_vec   = {payload_cur, ksep_cur};
        tx_word     = '0;
        for (int unsigned k = 0; k < WORDS; k++) begin
            if (32'(wc_nxt) == k) tx_word = frame_vec[32*(WORDS-1-k) +: 32];
        end
        tx_isk = (wc_nxt == LAST_WORD) ? LAST_ISK : 4'b0000;
        if (state_nxt != RUN) begin
            tx_word = SYNC_WORD;
            tx_isk  = SYNC_ISK;
        end
    end

    // FSM state register
    always_ff @(posedge TRG_CLK80 or negedge TRG_RST_N) begin
        if (!TRG_RST_N) state <= IDLE;
        else            state <= state_nxt;
    end

    // Counters, sticky sync request and error-injection flag
    always_ff @(posedge TRG_CLK80 or negedge TRG_RST_N) begin
        if (!TRG_RST_N) begin
            word_cnt   <= '0;
            frame_cnt  <= '0;
            sync_cnt   <= '0;
            sync_req_r <= 1'b0;
            inj_d      <= 1'b0;
            inj_flag   <= 1'b0;
        end else begin
            word_cnt  <= wc_nxt;
            frame_cnt <= frame_cnt_nxt;
            if (sync_entry)                     sync_cnt <= '0;
            else if (state == SYNC && boundary) sync_cnt <= sync_cnt + 8'd1;
            if (sync_entry)    sync_req_r <= 1'b0;
            else if (SYNC_REQ) sync_req_r <= 1'b1;
            inj_d    <= INJ_ERR;
            inj_flag <= load ? 1'b0 : inj_pend;
        end
    end

    // Frame registers loaded at each RUN frame boundary
    always_ff @(posedge TRG_CLK80 or negedge TRG_RST_N) begin
        if (!TRG_RST_N) begin
            payload_r <= '0;
            ksep_r    <= K_BC;
        end else if (load) begin
            payload_r <= payload_nxt;
            ksep_r    <= ksep_nxt;
        end
    end

    // Registered GTX outputs, aligned with word_cnt
    always_ff @(posedge TRG_CLK80 or negedge TRG_RST_N) begin
        if (!TRG_RST_N) begin
            TRG_TX_DATA <= SYNC_WORD;
            TRG_TX_ISK  <= SYNC_ISK;
            FRAME_START <= 1'b1;
            LTNCY_TRIG  <= 1'b0;
        end else begin
            TRG_TX_DATA <= tx_word;
            TRG_TX_ISK  <= tx_isk;
            FRAME_START <= (wc_nxt == '0);
            LTNCY_TRIG  <= (state_nxt == RUN) && (wc_nxt == '0) && (frame_cnt_nxt == '0);
        end
    end

endmodule

// File: tb/tb_trg_frame_tx.sv
// Directed bench for trg_frame_tx: WORDS=2 (data/counter/sync paths) and WORDS=3 (PRBS, injection).
module tb_trg_frame_tx;

    localparam logic [31:0] SYNC_W = 32'h50BC50BC;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        sd2, sreq2, inj2, ovf2;
    logic [1:0]  mode2;
    logic [55:0] din2;
    logic [11:0] bxn2;
    logic [31:0] data2;
    logic [3:0]  isk2;
    logic        fs2, lt2, lr2;

    logic        sd3, sreq3, inj3, ovf3;
    logic [1:0]  mode3;
    logic [87:0] din3;
    logic [11:0] bxn3;
    logic [31:0] data3;
    logic [3:0]  isk3;
    logic        fs3, lt3, lr3;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    trg_frame_tx #(.WORDS(2), .SYNC_FRAMES(16), .KSEL_TTC(1'b1), .PRBS_SEED(31'h7FFFFFFF)) u_dut2 (
        .TRG_CLK80(clk), .TRG_RST_N(rst_n), .TX_SYNC_DONE(sd2), .SYNC_REQ(sreq2),
        .MODE(mode2), .INJ_ERR(inj2), .DATA_IN(din2), .OVERFLOW(ovf2), .BXN_COUNTER(bxn2),
        .TRG_TX_DATA(data2), .TRG_TX_ISK(isk2), .FRAME_START(fs2), .LTNCY_TRIG(lt2),
        .LINK_READY(lr2)
    );

    trg_frame_tx #(.WORDS(3), .SYNC_FRAMES(16), .KSEL_TTC(1'b1), .PRBS_SEED(31'h7FFFFFFF)) u_dut3 (
        .TRG_CLK80(clk), .TRG_RST_N(rst_n), .TX_SYNC_DONE(sd3), .SYNC_REQ(sreq3),
        .MODE(mode3), .INJ_ERR(inj3), .DATA_IN(din3), .OVERFLOW(ovf3), .BXN_COUNTER(bxn3),
        .TRG_TX_DATA(data3), .TRG_TX_ISK(isk3), .FRAME_START(fs3), .LTNCY_TRIG(lt3),
        .LINK_READY(lr3)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference PRBS-31 frame: serial x^31+x^28+1, first bit into payload MSB
    task automatic prbs_frame(input logic [30:0] s_in, output logic [87:0] p, output logic [30:0] s_out);
        logic [30:0] s;
        logic        fb;
        s = s_in;
        p = '0;
        for (int i = 0; i < 88; i++) begin
            fb       = s[30] ^ s[27];
            p[87-i]  = fb;
            s        = {s[29:0], fb};
        end
        s_out = s;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  ksep_exp [4];
        logic [30:0] ms;
        logic [87:0] p;
        logic [95:0] fv;
        int          ones;

        ksep_exp[0] = 8'hBC; ksep_exp[1] = 8'hF7; ksep_exp[2] = 8'hFB; ksep_exp[3] = 8'hFD;

        sd2 = 0; sreq2 = 0; inj2 = 0; ovf2 = 0; mode2 = 2'd0; din2 = '0; bxn2 = '0;
        sd3 = 0; sreq3 = 0; inj3 = 0; ovf3 = 0; mode3 = 2'd1; din3 = '0; bxn3 = '0;

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_data", data2, SYNC_W);
        chk("rst_isk", isk2, 4'b0101);
        chk("rst_fs", fs2, 1'b1);
        chk("rst_lt", lt2, 1'b0);
        chk("rst_lr", lr2, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_data", data2, SYNC_W);
            chk("idle_fs", fs2, 1'b1);
            chk("idle_lr", lr2, 1'b0);
        end

        // WORDS=2 link bring-up with DATA_IN payload
        din2 = 56'hAABBCCDDEEFF11; bxn2 = 12'd1; sd2 = 1'b1;
        repeat (31) tick();
        chk("sync_last_data", data2, SYNC_W);
        chk("sync_last_lr", lr2, 1'b0);
        tick();
        chk("run_w0", data2, 32'hAABBCCDD);
        chk("run_w0_isk", isk2, 4'b0000);
        chk("run_w0_fs", fs2, 1'b1);
        chk("run_lr", lr2, 1'b1);
        chk("run_lt_first", lt2, 1'b1);
        tick();
        chk("run_w1", data2, 32'hEEFF11F7);
        chk("run_w1_isk", isk2, 4'b0001);
        chk("run_w1_lt", lt2, 1'b0);

        // New data and overflow sampled at the next boundary
        din2 = 56'h0123456789ABCD; bxn2 = 12'd2; ovf2 = 1'b1;
        tick();
        chk("lat_w0", data2, 32'h01234567);
        chk("lat_lt", lt2, 1'b0);
        tick();
        chk("ovf_w1", data2, 32'h89ABCDFC);

        ovf2 = 1'b0;
        for (int b = 0; b < 4; b++) begin
            bxn2 = 12'(b);
            tick();
            tick();
            chk("bxn_sep", data2[7:0], ksep_exp[b]);
        end

        // Counter payload: seventh RUN frame carries count 6
        mode2 = 2'd2; bxn2 = 12'd0;
        tick();
        chk("cnt_w0", data2, 32'h06060606);
        tick();
        chk("cnt_w1", data2, 32'h060606BC);
        mode2 = 2'd0;
        tick();
        chk("mode_back_w0", data2, 32'h01234567);

        // Sync request mid-frame: frame completes, then a full sync burst
        sreq2 = 1'b1;
        tick();
        sreq2 = 1'b0;
        chk("sreq_w1", data2, 32'h89ABCDBC);
        chk("sreq_w1_lr", lr2, 1'b1);
        tick();
        chk("resync_data", data2, SYNC_W);
        chk("resync_isk", isk2, 4'b0101);
        chk("resync_lr", lr2, 1'b0);
        repeat (31) tick();
        chk("resync_end_lr", lr2, 1'b0);
        tick();
        chk("rerun_w0", data2, 32'h01234567);
        chk("rerun_lr", lr2, 1'b1);
        chk("rerun_lt", lt2, 1'b1);

        ones = 0;
        repeat (511) begin
            tick();
            ones += int'(lt2);
        end
        chk("lt_gap", 64'(ones), 64'd0);
        tick();
        chk("lt_256", lt2, 1'b1);
        chk("lt_256_fs", fs2, 1'b1);

        // WORDS=3 PRBS payload with one injected error
        sd3 = 1'b1;
        repeat (47) tick();
        chk("p3_sync_lr", lr3, 1'b0);
        tick();
        chk("p3_w0_hand", data3, 32'h0000000E);
        chk("p3_lr", lr3, 1'b1);
        ms = 31'h7FFFFFFF;
        for (int f = 0; f < 3; f++) begin
            prbs_frame(ms, p, ms);
            if (f == 1) p[0] = ~p[0];
            fv = {p, 8'hBC};
            for (int k = 0; k < 3; k++) begin
                chk("p3_word", data3, fv[95-32*k -: 32]);
                chk("p3_isk", isk3, (k == 2) ? 4'b0001 : 4'b0000);
                if (f == 0 && k == 0) inj3 = 1'b1;
                if (f == 0 && k == 1) inj3 = 1'b0;
                tick();
            end
        end

        // Link drop on word 1 aborts the frame
        tick();
        chk("drop_pre_fs", fs3, 1'b0);
        sd3 = 1'b0;
        tick();
        chk("drop_fs", fs3, 1'b1);
        chk("drop_data", data3, SYNC_W);
        chk("drop_isk", isk3, 4'b0101);
        chk("drop_lr", lr3, 1'b0);

        // Asynchronous reset mid-frame on the running WORDS=2 link
        for (int i = 0; i < 4 && !(fs2 == 1'b0 && lr2 == 1'b1); i++) tick();
        chk("arst_pre_fs", fs2, 1'b0);
        chk("arst_pre_lr", lr2, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_data", data2, SYNC_W);
        chk("arst_isk", isk2, 4'b0101);
        chk("arst_fs", fs2, 1'b1);
        chk("arst_lr", lr2, 1'b0);
        chk("arst_lt", lt2, 1'b0);
        #10 rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/trg_frame_tx.md
Name: trg_frame_tx

Overview:
Parametrised trigger-link frame builder for GTX transmitters. It packs a WORDS-word frame for the GTX TXDATA/TXCHARISK ports. Each frame carries a DATA_WIDTH-bit payload followed by one trailing K-code frame separator. The block also provides link sync bursts, selectable payload sources (data, PRBS-31, counter), error injection and a latency-trigger strobe. It sits between the cluster packer and the GTX wrapper, one instance per fiber, and runs in the TXUSRCLK2 domain.

Parameters:
WORDS, 2, 32-bit GTX words per frame; legal range 2..4.
DATA_WIDTH, 32*WORDS-8, payload bits per frame; derived, not overridable.
SYNC_FRAMES, 16, number of sync frames sent after TX_SYNC_DONE rises or after a SYNC_REQ.
KSEL_TTC, 1, separator select: 1 = BXN_COUNTER[1:0]; 0 = local 2-bit frame counter.
PRBS_SEED, 31'h7FFFFFFF, LFSR seed, loaded on reset and throughout SYNC.

Ports:
TRG_CLK80  in  1  frame/word clock (TXUSRCLK2).
TRG_RST_N  in  1  asynchronous, active-low reset.
TX_SYNC_DONE  in  1  GTX phase alignment complete.
SYNC_REQ  in  1  request a sync burst; acted on at the next frame boundary.
MODE  in  2  payload source: 0 = DATA_IN, 1 = PRBS, 2 = counter, 3 = reserved (treated as 0).
INJ_ERR  in  1  rising edge flips one payload bit.
DATA_IN  in  DATA_WIDTH  payload input.
OVERFLOW  in  1  more clusters than fit in the frame.
BXN_COUNTER  in  12  TTC bunch counter.
TRG_TX_DATA  out  32  GTX TXDATA.
TRG_TX_ISK  out  4  GTX TXCHARISK.
FRAME_START  out  1  high while word 0 of a frame is on the outputs.
LTNCY_TRIG  out  1  one-cycle strobe every 256 RUN frames.
LINK_READY  out  1  high in RUN.

Behaviour:
- Reset (async assert, sync release). Outputs on reset: TRG_TX_DATA = 32'h50BC50BC, TRG_TX_ISK = 4'b0101, FRAME_START = 1, LTNCY_TRIG = 0, LINK_READY = 0. Internal state: state = IDLE, word_cnt = 0, frame_cnt = 0, lfsr = PRBS_SEED.
- word_cnt counts 0..WORDS-1 and wraps. It is forced to 0 on entry to IDLE. A frame boundary is the edge on which word_cnt == WORDS-1.
- FSM states and transitions:
  - IDLE -> SYNC when TX_SYNC_DONE = 1; the transition is taken at word_cnt = 0.
  - SYNC -> RUN after SYNC_FRAMES complete frames.
  - RUN -> SYNC at a frame boundary when SYNC_REQ is pending. SYNC_REQ is latched sticky and cleared on SYNC entry.
  - Any state -> IDLE on the next edge when TX_SYNC_DONE = 0; mid-frame aborts are allowed.
- IDLE and SYNC output: every word is 50BC50BC / 0101. frame_cnt is held at 0 and lfsr is held at PRBS_SEED.
- RUN frame load. At each boundary, and on the SYNC -> RUN edge, the following are registered:
  - payload_r <= source, with bit 0 inverted if an INJ_ERR rising edge occurred since the last load (one-shot).
  - ksep_r <= FC if OVERFLOW and MODE = 0; otherwise {BC, F7, FB, FD}[sel], where sel = BXN_COUNTER[1:0] (KSEL_TTC = 1) or the local counter (KSEL_TTC = 0).
- Payload sources:
  - PRBS: x^31+x^28+1. Serially advanced DATA_WIDTH steps per frame, with output bits MSB-first into payload. Unrolled combinationally.
  - Counter: {frame_cnt replicated}, truncated to DATA_WIDTH.
- Latency: DATA_IN sampled at boundary edge N appears on the output word in the following cycle.
- RUN word mapping, for word k:
  - k < WORDS-1: payload_r[DW-1-32k -: 32], ISK = 0000.
  - k = WORDS-1: {payload_r[23:0], ksep_r}, ISK = 0001.
- Output timing: outputs are registered and update on the same edge as word_cnt.
- frame_cnt: 8-bit, increments at every RUN boundary and wraps 255 -> 0. LTNCY_TRIG = 1 for the word-0 cycle when frame_cnt == 0 in RUN.
- Local separator counter: 2-bit, increments per RUN frame, cleared in SYNC.
- Simultaneous events:
  - SYNC_REQ together with TX_SYNC_DONE falling: IDLE wins.
  - INJ_ERR during SYNC: the flag is held until the first RUN load.
  - A MODE change takes effect at the next load only.

Decomposition:
- trg_link_pkg:
  - K-codes: K_BC, K_F7, K_FB, K_FD, K_FC.
  - SYNC_WORD = 32'h50BC50BC and SYNC_ISK = 4'b0101.
  - MODE encodings.
  - State enum {IDLE, SYNC, RUN}.
- Sub-module prbs31_par: parallel LFSR with parameter NBITS, inputs seed-load and advance, outputs next state and NBITS output bits.

Test Plan:
- Reset with TX_SYNC_DONE = 0 -> outputs continuously 50BC50BC/0101, LINK_READY = 0.
- WORDS = 2, raise TX_SYNC_DONE, MODE = 0, DATA_IN = 56'hAABBCCDDEEFF11, BXN = 1 -> after 16 sync frames, outputs AABBCCDD/0000 then EEFF11F7/0001, LINK_READY = 1.
- OVERFLOW = 1 with BXN = 2 -> last word low byte FC (not FB). BXN sweep 0..3 -> separator sequence BC, F7, FB, FD.
- WORDS = 3, MODE = 1 -> payload (88 bits) matches the software PRBS-31 model seeded 7FFFFFFF. A single INJ_ERR pulse -> exactly one frame with bit 0 inverted.
- SYNC_REQ pulse mid-frame in RUN -> current frame completes, then 16 sync frames, return to RUN. LTNCY_TRIG first fires on word 0 of the first RUN frame, then every 256 frames (512 cycles for WORDS = 2).
- Drop TX_SYNC_DONE on word 1 -> next cycle IDLE output, word_cnt = 0. Assert TRG_RST_N low mid-frame -> immediate reset values without waiting for a clock edge.
